// File: rtl/alarm_seq_if.sv
// Signal bundle between the time/alarm counters, the buttons and the alarm sequencer.
// The controller side takes the slave modport; the driving side takes master.
interface alarm_seq_if #(
    parameter int LW = 2,
    parameter int SW = 10
);
    logic          alarm_on;
    logic          match;
    logic [2:0]    day;
    logic          snooze;
    logic          stop;
    logic          buzz;
    logic          snoozing;
    logic [LW-1:0] snz_left;
    logic [SW-1:0] snz_sec;
    logic [1:0]    state;

    modport master (
        output alarm_on, match, day, snooze, stop,
        input  buzz, snoozing, snz_left, snz_sec, state
    );

    modport slave (
        input  alarm_on, match, day, snooze, stop,
        output buzz, snoozing, snz_left, snz_sec, state
    );
endinterface

// File: rtl/alarm_seq.sv
// Alarm sequencer: ring timeout, bounded snooze with countdown and per-day suppression.
// All outputs decode from registers, so there is no input-to-buzz combinational path.
module alarm_seq #(
    parameter int            SNOOZE_S    = 540,
    parameter int            RING_MAX    = 300,
    parameter int            MAX_SNOOZES = 3,
    parameter int            ND          = 7,
    parameter logic [ND-1:0] DAY_MASK    = 7'b1100000
) (
    input  logic        clk,
    input  logic        rst,
    alarm_seq_if.slave  bus
);
    localparam int LW_R = $clog2(MAX_SNOOZES + 1);
    localparam int SW_R = $clog2(SNOOZE_S);
    localparam int RW_R = $clog2(RING_MAX);
    localparam int LW   = (LW_R < 1) ? 1 : LW_R;
    localparam int SW   = (SW_R < 1) ? 1 : SW_R;
    localparam int RW   = (RW_R < 1) ? 1 : RW_R;

    localparam logic [LW-1:0] LEFT_MAX  = LW'(MAX_SNOOZES);
    localparam logic [SW-1:0] SEC_LOAD  = SW'(SNOOZE_S - 1);
    localparam logic [RW-1:0] RING_LAST = RW'(RING_MAX - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2,
        DONE   = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [LW-1:0] snz_left_q, snz_left_d;
    logic [SW-1:0] snz_sec_q, snz_sec_d;
    logic [RW-1:0] ring_q, ring_d;
    logic          masked;

    // Out-of-range day never matches a mask bit, so it rings.
    always_comb begin
        masked = 1'b0;
        for (int i = 0; i < ND; i++) begin
            if (int'(bus.day) == i) masked = DAY_MASK[i];
        end
    end

    always_comb begin
        state_d    = state_q;
        snz_left_d = snz_left_q;
        snz_sec_d  = snz_sec_q;
        ring_d     = ring_q;
        if (!bus.alarm_on) begin
            state_d    = IDLE;
            snz_left_d = LEFT_MAX;
            snz_sec_d  = '0;
            ring_d     = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.match && !masked) begin
                        state_d = RING;
                        ring_d  = '0;
                    end
                end
                RING: begin
                    if (bus.stop) begin
                        state_d = DONE;
                    end else if (bus.snooze && snz_left_q != '0) begin
                        state_d    = SNOOZE;
                        snz_left_d = snz_left_q - LW'(1);
                        snz_sec_d  = SEC_LOAD;
                    end else if (ring_q == RING_LAST) begin
                        state_d = DONE;
                    end else begin
                        ring_d = ring_q + RW'(1);
                    end
                end
                SNOOZE: begin
                    if (bus.stop) begin
                        state_d = DONE;
                    end else if (snz_sec_q == '0) begin
                        state_d = RING;
                        ring_d  = '0;
                    end else begin
                        snz_sec_d = snz_sec_q - SW'(1);
                    end
                end
                DONE: begin
                    // Hold off until the alarm minute ends so it cannot re-trigger.
                    if (!bus.match) begin
                        state_d    = IDLE;
                        snz_left_d = LEFT_MAX;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            snz_left_q <= LEFT_MAX;
            snz_sec_q  <= '0;
            ring_q     <= '0;
        end else begin
            state_q    <= state_d;
            snz_left_q <= snz_left_d;
            snz_sec_q  <= snz_sec_d;
            ring_q     <= ring_d;
        end
    end

    assign bus.buzz     = (state_q == RING);
    assign bus.snoozing = (state_q == SNOOZE);
    assign bus.snz_left = snz_left_q;
    assign bus.snz_sec  = snz_sec_q;
    assign bus.state    = state_q;
endmodule

// File: tb/tb_alarm_seq.sv
// Directed bench for alarm_seq with SNOOZE_S=5, RING_MAX=8, MAX_SNOOZES=2.
// Inputs change 1 time unit after a rising edge; outputs are read at the same point.
module tb_alarm_seq;
    localparam logic [1:0] S_IDLE = 2'd0, S_RING = 2'd1, S_SNZ = 2'd2, S_DONE = 2'd3;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    alarm_seq_if #(.LW(2), .SW(3)) bus ();

    alarm_seq #(
        .SNOOZE_S(5), .RING_MAX(8), .MAX_SNOOZES(2), .ND(7), .DAY_MASK(7'b1100000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.alarm_on = 1'b1; bus.match = 1'b0; bus.day = 3'd2;
        bus.snooze = 1'b0; bus.stop = 1'b0;
        tick(); tick();
        n_cmp++; if (bus.state !== S_IDLE) begin n_err++; $display("FAIL reset_state: got %0d want %0d", bus.state, S_IDLE); end
        n_cmp++; if (bus.buzz !== 1'b0 || bus.snoozing !== 1'b0) begin n_err++; $display("FAIL reset_buzz: got buzz=%b snoozing=%b want 0/0", bus.buzz, bus.snoozing); end
        n_cmp++; if (bus.snz_left !== 2'd2 || bus.snz_sec !== 3'd0) begin n_err++; $display("FAIL reset_cnt: got left=%0d sec=%0d want 2/0", bus.snz_left, bus.snz_sec); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_ring_timeout();
        int buzz_cnt = 0;
        logic retrig = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        n_cmp++; if (bus.state !== S_IDLE) begin n_err++; $display("FAIL pre_match_idle: got %0d want %0d", bus.state, S_IDLE); end
        bus.match = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.buzz === 1'b1) buzz_cnt++;
        end
        n_cmp++; if (buzz_cnt !== 8) begin n_err++; $display("FAIL ring_len: got %0d want %0d", buzz_cnt, 8); end
        tick();
        n_cmp++; if (bus.state !== S_DONE || bus.buzz !== 1'b0) begin n_err++; $display("FAIL ring_timeout: got state=%0d buzz=%b want %0d/0", bus.state, bus.buzz, S_DONE); end
        for (int i = 0; i < 50; i++) begin
            tick();
            if (bus.buzz !== 1'b0 || bus.state !== S_DONE) retrig = 1'b1;
        end
        n_cmp++; if (retrig !== 1'b0) begin n_err++; $display("FAIL no_retrigger: got %b want 0", retrig); end
        bus.match = 1'b0;
        tick();
        n_cmp++; if (bus.state !== S_IDLE || bus.snz_left !== 2'd2) begin n_err++; $display("FAIL done_to_idle: got state=%0d left=%0d want %0d/2", bus.state, bus.snz_left, S_IDLE); end
    endtask

    task automatic test_snooze();
        logic [2:0] exp_sec;
        bus.match = 1'b1;
        tick(); tick(); tick();
        bus.snooze = 1'b1;
        tick();
        bus.snooze = 1'b0;
        n_cmp++; if (bus.state !== S_SNZ || bus.snoozing !== 1'b1 || bus.buzz !== 1'b0) begin n_err++; $display("FAIL snz_enter: got state=%0d snoozing=%b buzz=%b want %0d/1/0", bus.state, bus.snoozing, bus.buzz, S_SNZ); end
        n_cmp++; if (bus.snz_left !== 2'd1) begin n_err++; $display("FAIL snz_left1: got %0d want 1", bus.snz_left); end
        for (int i = 0; i < 5; i++) begin
            exp_sec = 3'(4 - i);
            n_cmp++; if (bus.snz_sec !== exp_sec || bus.buzz !== 1'b0) begin n_err++; $display("FAIL snz_count: got sec=%0d buzz=%b want %0d/0", bus.snz_sec, bus.buzz, exp_sec); end
            tick();
        end
        n_cmp++; if (bus.buzz !== 1'b1 || bus.snz_left !== 2'd1) begin n_err++; $display("FAIL snz_rering: got buzz=%b left=%0d want 1/1", bus.buzz, bus.snz_left); end
        // Second snooze held through the interval; the third request is this held level.
        bus.snooze = 1'b1;
        tick();
        n_cmp++; if (bus.state !== S_SNZ || bus.snz_left !== 2'd0) begin n_err++; $display("FAIL snz_second: got state=%0d left=%0d want %0d/0", bus.state, bus.snz_left, S_SNZ); end
        tick(); tick(); tick(); tick();
        n_cmp++; if (bus.state !== S_SNZ || bus.snz_sec !== 3'd0) begin n_err++; $display("FAIL snz_held_ignored: got state=%0d sec=%0d want %0d/0", bus.state, bus.snz_sec, S_SNZ); end
        for (int i = 0; i < 8; i++) begin
            tick();
            n_cmp++; if (bus.buzz !== 1'b1) begin n_err++; $display("FAIL snz_exhausted_ring: cycle %0d got buzz=%b want 1", i, bus.buzz); end
        end
        tick();
        n_cmp++; if (bus.state !== S_DONE) begin n_err++; $display("FAIL snz_final_timeout: got %0d want %0d", bus.state, S_DONE); end
        bus.snooze = 1'b0; bus.match = 1'b0;
        tick();
        n_cmp++; if (bus.state !== S_IDLE || bus.snz_left !== 2'd2) begin n_err++; $display("FAIL snz_reload: got state=%0d left=%0d want %0d/2", bus.state, bus.snz_left, S_IDLE); end
    endtask

    task automatic test_stop_priority();
        logic rebuzz = 1'b0;
        bus.match = 1'b1;
        tick(); tick();
        bus.stop = 1'b1; bus.snooze = 1'b1;
        tick();
        bus.stop = 1'b0; bus.snooze = 1'b0;
        n_cmp++; if (bus.state !== S_DONE || bus.snz_left !== 2'd2) begin n_err++; $display("FAIL stop_wins: got state=%0d left=%0d want %0d/2", bus.state, bus.snz_left, S_DONE); end
        bus.match = 1'b0;
        tick();
        bus.match = 1'b1;
        tick();
        bus.snooze = 1'b1;
        tick();
        bus.snooze = 1'b0;
        tick();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        n_cmp++; if (bus.state !== S_DONE || bus.snz_left !== 2'd1) begin n_err++; $display("FAIL stop_in_snz: got state=%0d left=%0d want %0d/1", bus.state, bus.snz_left, S_DONE); end
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.buzz !== 1'b0) rebuzz = 1'b1;
        end
        n_cmp++; if (rebuzz !== 1'b0) begin n_err++; $display("FAIL stop_no_rebuzz: got %b want 0", rebuzz); end
        bus.match = 1'b0;
        tick();
    endtask

    task automatic test_day_mask();
        bus.day = 3'd5; bus.match = 1'b1;
        tick(); tick(); tick();
        n_cmp++; if (bus.state !== S_IDLE || bus.buzz !== 1'b0) begin n_err++; $display("FAIL mask_day5: got state=%0d buzz=%b want %0d/0", bus.state, bus.buzz, S_IDLE); end
        bus.day = 3'd6;
        tick(); tick();
        n_cmp++; if (bus.state !== S_IDLE || bus.buzz !== 1'b0) begin n_err++; $display("FAIL mask_day6: got state=%0d buzz=%b want %0d/0", bus.state, bus.buzz, S_IDLE); end
        bus.day = 3'd7;
        tick();
        n_cmp++; if (bus.state !== S_RING || bus.buzz !== 1'b1) begin n_err++; $display("FAIL day7_rings: got state=%0d buzz=%b want %0d/1", bus.state, bus.buzz, S_RING); end
        // Mask is only sampled on entry: moving to a masked day mid-ring keeps ringing.
        bus.day = 3'd6;
        tick();
        n_cmp++; if (bus.buzz !== 1'b1) begin n_err++; $display("FAIL mask_midring: got buzz=%b want 1", bus.buzz); end
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0; bus.match = 1'b0; bus.day = 3'd2;
        tick();
    endtask

    task automatic test_enable_reset();
        bus.match = 1'b1;
        tick();
        bus.snooze = 1'b1;
        tick();
        bus.snooze = 1'b0;
        tick();
        bus.alarm_on = 1'b0;
        tick();
        n_cmp++; if (bus.state !== S_IDLE || bus.snz_left !== 2'd2 || bus.snz_sec !== 3'd0) begin n_err++; $display("FAIL alarm_off: got state=%0d left=%0d sec=%0d want %0d/2/0", bus.state, bus.snz_left, bus.snz_sec, S_IDLE); end
        bus.alarm_on = 1'b1;
        tick();
        n_cmp++; if (bus.state !== S_RING) begin n_err++; $display("FAIL re_enable_ring: got %0d want %0d", bus.state, S_RING); end
        tick(); tick();
        rst = 1'b1; bus.snooze = 1'b1;
        tick();
        n_cmp++; if (bus.state !== S_IDLE || bus.buzz !== 1'b0 || bus.snoozing !== 1'b0) begin n_err++; $display("FAIL rst_midring: got state=%0d buzz=%b snoozing=%b want %0d/0/0", bus.state, bus.buzz, bus.snoozing, S_IDLE); end
        n_cmp++; if (bus.snz_left !== 2'd2 || bus.snz_sec !== 3'd0) begin n_err++; $display("FAIL rst_midring_cnt: got left=%0d sec=%0d want 2/0", bus.snz_left, bus.snz_sec); end
        rst = 1'b0; bus.snooze = 1'b0; bus.match = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_ring_timeout();
        test_snooze();
        test_stop_priority();
        test_day_mask();
        test_enable_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
